// File: rtl/uart_pkg.sv
// Types and constants shared by the UART TX serializer slice:
// FSM state encoding, parity-type selectors and the default payload width.
package uart_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARM   = 2'd1,
        S_SHIFT = 2'd2
    } state_t;

endpackage

// File: rtl/uart_tx_serializer_if.sv
// Handshake bundle between the TX controller (master) and the serializer (slave).
interface uart_tx_serializer_if #(
    parameter int DATA_WIDTH = uart_pkg::DEFAULT_DATA_WIDTH
);
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  DATA_VALID;
    logic                  busy;
    logic                  ser_en;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic                  ser_data;
    logic                  ser_done;
    logic                  par_bit;

    modport master (
        output P_DATA, DATA_VALID, busy, ser_en, PAR_EN, PAR_TYP,
        input  ser_data, ser_done, par_bit
    );

    modport slave (
        input  P_DATA, DATA_VALID, busy, ser_en, PAR_EN, PAR_TYP,
        output ser_data, ser_done, par_bit
    );
endinterface

// File: rtl/uart_parity_calc.sv
// Frame parity generator: even = XOR-reduce, odd = XNOR-reduce of the payload.
module uart_parity_calc
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  PAR_TYP,
    output logic                  parity
);
    always_comb begin
        parity = ^data;
        if (PAR_TYP == PAR_ODD) begin
            parity = ~^data;
        end
    end
endmodule

// File: rtl/uart_tx_serializer.sv
// LSB-first payload serializer for the UART transmitter.
// Define UART_TX_SERIALIZER_PARITY_EN to build the parity capture path.
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  CLK,
    input  logic                  RST,
    uart_tx_serializer_if.slave   bus
);
    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_WIDTH - 1);

    state_t                state_q;
    logic [DATA_WIDTH-1:0] shreg_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  load;
    logic                  done;

    assign load         = bus.DATA_VALID & ~bus.busy;
    assign done         = (state_q == S_SHIFT) && (cnt_q == LAST_IDX);
    assign bus.ser_data = shreg_q[0];
    assign bus.ser_done = done;

    // A load wins over ser_en in every state, restarting the frame.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= S_IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
        end else if (load) begin
            state_q <= S_ARM;
            shreg_q <= bus.P_DATA;
            cnt_q   <= '0;
        end else if (bus.ser_en) begin
            case (state_q)
                S_ARM: begin
                    state_q <= S_SHIFT;
                end
                S_SHIFT: begin
                    if (done) begin
                        // Final bit leaves the register untouched so ser_data holds it.
                        state_q <= S_IDLE;
                        cnt_q   <= '0;
                    end else begin
                        shreg_q <= {1'b0, shreg_q[DATA_WIDTH-1:1]};
                        cnt_q   <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= state_q;
                end
            endcase
        end
    end

`ifdef UART_TX_SERIALIZER_PARITY_EN
    logic par_calc;
    logic par_q;

    uart_parity_calc #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_parity (
        .data   (bus.P_DATA),
        .PAR_TYP(bus.PAR_TYP),
        .parity (par_calc)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            par_q <= 1'b0;
        end else if (load) begin
            par_q <= bus.PAR_EN & par_calc;
        end
    end

    assign bus.par_bit = par_q;
`else
    logic unused_par_cfg;
    assign unused_par_cfg = bus.PAR_EN ^ bus.PAR_TYP;
    assign bus.par_bit    = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Self-checking bench for uart_tx_serializer: vector table, directed corner
// sequences and randomized traffic against a frame-level reference model.
module tb_uart_tx_serializer;
    import uart_pkg::*;

    localparam int DW = 8;

    logic CLK = 1'b0;
    logic RST = 1'b0;

    uart_tx_serializer_if #(.DATA_WIDTH(DW)) bus ();

    uart_tx_serializer #(.DATA_WIDTH(DW)) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    always #5 CLK = ~CLK;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: m counts ser_en cycles since the last load.
    // m==0: armed (bit 0 visible); m in 1..DW: bit m-1 on the line;
    // m==DW+1: frame over, last bit held. Nothing loaded since reset -> 0.
    int          m_cnt = DW + 1;
    logic [DW-1:0] m_pay = '0;
    bit          m_loaded = 1'b0;
    logic        m_par = 1'b0;

    function automatic logic ref_par(logic [DW-1:0] d, logic en, logic typ);
`ifdef UART_TX_SERIALIZER_PARITY_EN
        logic p;
        p = ($countones(d) % 2) == 1;
        if (!en) return 1'b0;
        return typ ? ~p : p;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic exp_ser();
        int idx;
        if (!m_loaded) return 1'b0;
        idx = (m_cnt == 0) ? 0 : m_cnt - 1;
        if (idx > DW - 1) idx = DW - 1;
        return m_pay[idx];
    endfunction

    function automatic logic exp_done();
        return m_loaded && (m_cnt == DW);
    endfunction

    task automatic model_reset();
        m_cnt    = DW + 1;
        m_pay    = '0;
        m_loaded = 1'b0;
        m_par    = 1'b0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_model(input string name);
        chk({name, ".ser_data"}, 32'(bus.ser_data), 32'(exp_ser()));
        chk({name, ".ser_done"}, 32'(bus.ser_done), 32'(exp_done()));
        chk({name, ".par_bit"},  32'(bus.par_bit),  32'(m_par));
    endtask

    // Advance one clock; the model consumes the inputs present at the edge.
    task automatic step();
        if (!RST) begin
            model_reset();
        end else if (bus.DATA_VALID && !bus.busy) begin
            m_pay    = bus.P_DATA;
            m_cnt    = 0;
            m_loaded = 1'b1;
            m_par    = ref_par(bus.P_DATA, bus.PAR_EN, bus.PAR_TYP);
        end else if (bus.ser_en && m_cnt <= DW) begin
            m_cnt++;
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic load(input logic [DW-1:0] d, input logic en, input logic typ);
        bus.P_DATA     = d;
        bus.PAR_EN     = en;
        bus.PAR_TYP    = typ;
        bus.DATA_VALID = 1'b1;
        bus.busy       = 1'b0;
        bus.ser_en     = 1'b0;
        step();
        bus.DATA_VALID = 1'b0;
    endtask

    typedef struct {
        logic [DW-1:0] data;
        logic          par_en;
        logic          par_typ;
        logic          exp_par;   // parity expected when the parity path is built
        logic [DW-1:0] exp_bits;  // bit k expected in ser_en cycle k+2
    } vec_t;

    vec_t tbl[6];

    initial begin
        logic [DW-1:0] d;
        logic          ep;

        tbl[0] = '{8'hA5, 1'b1, 1'b0, 1'b0, 8'hA5};
        tbl[1] = '{8'h80, 1'b1, 1'b1, 1'b0, 8'h80};
        tbl[2] = '{8'h80, 1'b1, 1'b0, 1'b1, 8'h80};
        tbl[3] = '{8'h80, 1'b0, 1'b0, 1'b0, 8'h80};
        tbl[4] = '{8'h3C, 1'b1, 1'b1, 1'b1, 8'h3C};
        tbl[5] = '{8'hFF, 1'b1, 1'b0, 1'b0, 8'hFF};

        bus.P_DATA = '0; bus.DATA_VALID = 1'b0; bus.busy = 1'b0;
        bus.ser_en = 1'b0; bus.PAR_EN = 1'b0; bus.PAR_TYP = 1'b0;

        // Reset state
        repeat (2) step();
        chk("rst.ser_data", 32'(bus.ser_data), 32'd0);
        chk("rst.ser_done", 32'(bus.ser_done), 32'd0);
        chk("rst.par_bit",  32'(bus.par_bit),  32'd0);
        chk("rst.state",    32'(dut.state_q),  32'(S_IDLE));
        RST = 1'b1;

        // Load accepted on the first edge after release
        load(8'h5A, 1'b1, 1'b0);
        chk("first_load.state", 32'(dut.state_q), 32'(S_ARM));
        chk("first_load.ser_data", 32'(bus.ser_data), 32'd0);

        // Vector table: full frames
        foreach (tbl[i]) begin
            load(tbl[i].data, tbl[i].par_en, tbl[i].par_typ);
`ifdef UART_TX_SERIALIZER_PARITY_EN
            ep = tbl[i].exp_par;
`else
            ep = 1'b0;
`endif
            chk($sformatf("tbl%0d.par_bit", i), 32'(bus.par_bit), 32'(ep));
            for (int c = 1; c <= 9; c++) begin
                bus.ser_en = 1'b1;
                if (c >= 2)
                    chk($sformatf("tbl%0d.bit%0d", i, c - 2), 32'(bus.ser_data),
                        32'(tbl[i].exp_bits[c-2]));
                chk($sformatf("tbl%0d.done_c%0d", i, c), 32'(bus.ser_done), 32'(c == 9));
                check_model($sformatf("tbl%0d.model_c%0d", i, c));
                step();
            end
            chk($sformatf("tbl%0d.end_state", i), 32'(dut.state_q), 32'(S_IDLE));
            bus.ser_en = 1'b1;
            step();
            chk($sformatf("tbl%0d.idle_ignore", i), 32'(dut.state_q), 32'(S_IDLE));
            check_model($sformatf("tbl%0d.idle", i));
        end

        // Stall after bit 3: ser_en low for 3 cycles holds everything
        d = 8'h96;
        load(d, 1'b1, 1'b0);
        bus.ser_en = 1'b1;
        repeat (5) step();
        bus.ser_en = 1'b0;
        for (int s = 0; s < 3; s++) begin
            chk("stall.ser_data", 32'(bus.ser_data), 32'(d[4]));
            chk("stall.cnt", 32'(dut.cnt_q), 32'd4);
            check_model("stall.model");
            step();
        end
        bus.ser_en = 1'b1;
        for (int k = 4; k < DW; k++) begin
            chk($sformatf("stall.bit%0d", k), 32'(bus.ser_data), 32'(d[k]));
            chk($sformatf("stall.done%0d", k), 32'(bus.ser_done), 32'(k == DW - 1));
            step();
        end
        chk("stall.end_state", 32'(dut.state_q), 32'(S_IDLE));

        // Reload mid-shift at counter 4
        load(8'h55, 1'b1, 1'b0);
        bus.ser_en = 1'b1;
        repeat (5) step();
        chk("reload.pre_cnt", 32'(dut.cnt_q), 32'd4);
        bus.P_DATA = 8'h3C; bus.DATA_VALID = 1'b1; bus.busy = 1'b0;
        bus.PAR_EN = 1'b1; bus.PAR_TYP = 1'b0;
        step();
        bus.DATA_VALID = 1'b0;
        chk("reload.state", 32'(dut.state_q), 32'(S_ARM));
        chk("reload.cnt", 32'(dut.cnt_q), 32'd0);
        chk("reload.par_bit", 32'(bus.par_bit), 32'(ref_par(8'h3C, 1'b1, 1'b0)));
        d = 8'h3C;
        step();
        for (int k = 0; k < DW; k++) begin
            chk($sformatf("reload.bit%0d", k), 32'(bus.ser_data), 32'(d[k]));
            check_model($sformatf("reload.model%0d", k));
            step();
        end

        // Asynchronous reset mid-frame at counter 5
        load(8'hFF, 1'b1, 1'b1);
        bus.ser_en = 1'b1;
        repeat (6) step();
        chk("rstmid.pre_cnt", 32'(dut.cnt_q), 32'd5);
        chk("rstmid.pre_ser", 32'(bus.ser_data), 32'd1);
        #2;
        RST = 1'b0;
        #1;
        chk("rstmid.ser_data", 32'(bus.ser_data), 32'd0);
        chk("rstmid.ser_done", 32'(bus.ser_done), 32'd0);
        chk("rstmid.par_bit",  32'(bus.par_bit),  32'd0);
        chk("rstmid.state",    32'(dut.state_q),  32'(S_IDLE));
        chk("rstmid.cnt",      32'(dut.cnt_q),    32'd0);
        model_reset();
        step();
        RST = 1'b1;
        bus.DATA_VALID = 1'b1; bus.busy = 1'b1; bus.P_DATA = 8'hC3;
        step();
        chk("busy_block.state", 32'(dut.state_q), 32'(S_IDLE));
        check_model("busy_block.model");
        bus.DATA_VALID = 1'b0; bus.busy = 1'b0;

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            bus.DATA_VALID = ($urandom_range(0, 11) == 0);
            bus.busy       = ($urandom_range(0, 3) == 0);
            bus.ser_en     = ($urandom_range(0, 4) != 0);
            bus.P_DATA     = DW'($urandom);
            bus.PAR_EN     = 1'($urandom);
            bus.PAR_TYP    = 1'($urandom);
            check_model("rand");
            if ($urandom_range(0, 599) == 0) begin
                #2;
                RST = 1'b0;
                #1;
                model_reset();
                check_model("rand_rst");
                step();
                RST = 1'b1;
            end else begin
                step();
            end
        end
        check_model("rand_final");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/uart_tx_serializer.md
UART_TX_SERIALIZER -- requirements
Module: uart_tx_serializer

Interface
REQ-001 Parameter DATA_WIDTH, default 8, is the frame payload width in bits.
REQ-002 Port CLK  input  1  is the system clock; all state is updated on its rising edge.
REQ-003 Port RST  input  1  is the reset: asynchronous, active-low.
REQ-004 Port P_DATA  input  DATA_WIDTH  is the parallel payload, sampled on load.
REQ-005 Port DATA_VALID  input  1  marks P_DATA as valid.
REQ-006 Port busy  input  1  is the TX controller busy flag.
REQ-007 Port ser_en  input  1  is the TX controller serialize enable.
REQ-008 Port PAR_EN  input  1  enables parity; 0 forces the captured parity to 0.
REQ-009 Port PAR_TYP  input  1  selects parity type: 0 = even, 1 = odd.
REQ-010 Port ser_data  output  1  is the current serial bit, equal to shift register bit 0.
REQ-011 Port ser_done  output  1  means the last payload bit is on ser_data.
REQ-012 Port par_bit  output  1  is the parity bit captured for the current frame.

Function
REQ-013 A load occurs on any cycle with DATA_VALID=1 and busy=0.
REQ-014 On load, the block shall:
- capture P_DATA into the shift register;
- clear the bit counter;
- enter S_ARM.
REQ-015 On load, par_bit shall be registered as follows:
- PAR_EN=0: 0;
- PAR_TYP=0: XOR-reduce(P_DATA);
- PAR_TYP=1: XNOR-reduce(P_DATA).
REQ-016 State S_IDLE: no shift; go to S_ARM on load.
REQ-017 State S_ARM: the TX controller holds ser_en=1 during the start-bit cycle. The first ser_en=1 cycle shall not shift and shall move to S_SHIFT.
REQ-018 State S_SHIFT: each ser_en=1 cycle shall shift right by one (zero fill) and increment the counter.
REQ-019 ser_en=0 in S_ARM or S_SHIFT shall hold all state.
REQ-020 ser_done shall be a combinational decode of registers: 1 exactly when state=S_SHIFT and counter=DATA_WIDTH-1.
REQ-021 A ser_en=1 cycle with ser_done=1 shall return to S_IDLE and clear the counter. The shift register keeps its shifted value.
REQ-022 Payload is transmitted LSB first. Bit k is on ser_data during the (k+2)th ser_en cycle after load.
REQ-023 A load while in S_ARM or S_SHIFT shall take priority over ser_en and restart the frame in S_ARM. par_bit shall be recaptured.
REQ-024 The counter width shall be clog2(DATA_WIDTH). No counter wrap is reachable.
REQ-025 In S_IDLE, ser_en=1 shall be ignored.

Reset
REQ-026 RST low shall asynchronously force all of the following, regardless of the current state (mid-frame included):
- state=S_IDLE;
- shift register=0;
- counter=0;
- par_bit=0;
- ser_data=0;
- ser_done=0.
REQ-027 The first load shall be accepted on the first rising edge after RST deasserts.

Configuration
REQ-028 Macro UART_TX_SERIALIZER_PARITY_EN defined: parity capture per REQ-015.
REQ-029 Macro undefined: no parity logic is compiled, par_bit is tied to 0, and PAR_EN and PAR_TYP are ignored. Ports are unchanged.

Structure
REQ-030 Shared package uart_pkg shall hold:
- state encodings S_IDLE, S_ARM, S_SHIFT;
- parity-type constants PAR_EVEN=0, PAR_ODD=1;
- default DATA_WIDTH.
REQ-031 Parity generation shall be one sub-module, uart_parity_calc (data, PAR_TYP in; parity out). It is instantiated only under the macro.

Verification
REQ-032 Even parity: P_DATA=0xA5, PAR_EN=1, PAR_TYP=0, load, then ser_en high for 9 cycles.
- Expect: par_bit=0.
- Expect: ser_data over ser_en cycles 2..9 = 1,0,1,0,0,1,0,1.
- Expect: ser_done high only in cycle 9.
REQ-033 Odd parity: P_DATA=0x80, PAR_TYP=1.
- Expect: par_bit=0.
- Repeat with PAR_TYP=0: expect par_bit=1.
- Repeat with PAR_EN=0: expect par_bit=0.
REQ-034 Stalled shift: drop ser_en for 3 cycles after bit 3.
- Expect: ser_data and counter held.
- Expect: the frame completes with bits in order and ser_done on the final bit.
REQ-035 Reload: in S_SHIFT with counter=4, DATA_VALID=1, busy=0, P_DATA=0x3C.
- Expect: S_ARM.
- Expect: counter=0.
- Expect: subsequent bits are 0,0,1,1,1,1,0,0.
REQ-036 Reset mid-frame: RST low at counter=5.
- Expect: all outputs 0 asynchronously.
- After release, DATA_VALID with busy=1: no load; state stays S_IDLE.
